// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// Contents: loader FSM state enum, bytes per instruction word, default
// terminator word.
package loader_pkg;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_WRITE   = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam logic [31:0] END_WORD_DEF   = 32'hFFFF_FFFF;

endpackage

// File: rtl/uart_word_assembler.sv
// Little-endian byte-to-word assembler. Collects four received bytes into a
// 32-bit word; a break (or, with LOADER_TIMEOUT_EN defined, an inter-byte
// timeout) discards the partial word.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   en                 accept bytes/breaks (low once loading is finished)
//   rx_valid, rx_data  received byte strobe and data
//   rx_break           abort the partial word; wins over a same-cycle byte
//   word, word_valid   completed word, valid in the cycle of its last byte
//   timeout            one-cycle pulse when a partial word times out
module uart_word_assembler import loader_pkg::*; #(
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_break,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        timeout
);

  logic [1:0]  byte_cnt;
  logic [23:0] asm_q;   // bytes 0..2; byte 3 is taken straight from rx_data
  logic        take;

  assign take       = en && rx_valid && !rx_break;
  assign word_valid = take && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  // Combinational completion lets the write strobe follow the last byte by one cycle.
  assign word       = {rx_data, asm_q};

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  assign timeout = en && !rx_valid && !rx_break && (byte_cnt != 2'd0) &&
                   (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!resetn || byte_cnt == 2'd0 || rx_valid || timeout) tmo_cnt <= '0;
    else                                                    tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      byte_cnt <= 2'd0;
      asm_q    <= '0;
    end else if ((en && rx_break) || timeout) begin
      byte_cnt <= 2'd0;
    end else if (take) begin
      case (byte_cnt)
        2'd0:    asm_q[7:0]   <= rx_data;
        2'd1:    asm_q[15:8]  <= rx_data;
        2'd2:    asm_q[23:16] <= rx_data;
        default: ;
      endcase
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/uart_imem_loader.sv
// UART boot loader: writes received little-endian 32-bit words to
// instruction memory at incrementing addresses and holds the core in reset
// until a terminator word arrives. Optional inter-byte timeout is built when
// LOADER_TIMEOUT_EN is defined.
// Ports:
//   clk, resetn                       clock, synchronous active-low reset
//   rx_valid, rx_data, rx_break       UART receiver interface
//   imem_we, imem_addr, imem_wdata    instruction memory write port
//   write_done, cpu_rst               loading finished / core reset
//   word_count                        words written so far
//   overflow, timeout_err             sticky error flags
module uart_imem_loader import loader_pkg::*; #(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [31:0] END_WORD    = END_WORD_DEF,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              write_done,
  output logic              cpu_rst,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow,
  output logic              timeout_err
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_n;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       word;
  logic              word_valid, tmo, ovf_hit;

  uart_word_assembler #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_asm (
    .clk        (clk),
    .resetn     (resetn),
    .en         (state != S_DONE),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_break   (rx_break),
    .word       (word),
    .word_valid (word_valid),
    .timeout    (tmo)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_COLLECT;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    ovf_hit = 1'b0;
    case (state)
      S_COLLECT: if (word_valid) begin
        if (word == END_WORD)          state_n = S_DONE;
        else if (word_count == DEPTH) begin
          ovf_hit = 1'b1;
          state_n = S_DONE;
        end else                       state_n = S_WRITE;
      end
      S_WRITE: state_n = S_COLLECT;
      S_DONE:  state_n = S_DONE;
      default: state_n = S_COLLECT;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      word_addr  <= '0;
      word_count <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      write_done <= 1'b0;
      cpu_rst    <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      imem_we    <= (state_n == S_WRITE);
      write_done <= (state_n == S_DONE);
      cpu_rst    <= (state_n != S_DONE);
      if (state_n == S_WRITE) begin
        imem_addr  <= word_addr;
        imem_wdata <= word;
      end
      if (state == S_WRITE) begin
        word_addr  <= word_addr + 1'b1;
        word_count <= word_count + 1'b1;
      end
      if (ovf_hit) overflow <= 1'b1;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!resetn)  timeout_err <= 1'b0;
    else if (tmo) timeout_err <= 1'b1;
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule
